// File: rtl/ddr_ca_dly_ctrl.sv
// Command-driven tap controller for the DDR3 CA lane IOD delay lines.
// Define DDR_CA_DLY_STICKY_EN to enable per-lane sticky out-of-range tracking.
module ddr_ca_dly_ctrl #(
    parameter int unsigned LANES      = 8,
    parameter int unsigned TAP_W      = 8,
    parameter int unsigned TAP_MAX    = 127,
    parameter int unsigned INIT_TAP   = 1,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic                     FAB_CLK,
    input  logic                     SYNC_RST,
    input  logic                     CMD_VALID,
    output logic                     CMD_READY,
    input  logic [$clog2(LANES)-1:0] CMD_LANE,
    input  logic [1:0]               CMD_OP,
    input  logic [TAP_W-1:0]         CMD_COUNT,
    output logic                     DONE,
    output logic                     DONE_ERR,
    output logic                     BUSY,
    output logic [LANES-1:0]         DELAY_LINE_LOAD,
    output logic [LANES-1:0]         DELAY_LINE_MOVE,
    output logic [LANES-1:0]         DELAY_LINE_DIRECTION,
    input  logic [LANES-1:0]         DELAY_LINE_OUT_OF_RANGE,
    output logic [LANES*TAP_W-1:0]   TAP_VALUE,
    output logic [LANES-1:0]         OOR_STICKY
);

    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned CNT_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b11;

    localparam logic [TAP_W-1:0] TAP_MAX_V  = TAP_W'(TAP_MAX);
    localparam logic [TAP_W-1:0] INIT_TAP_V = TAP_W'(INIT_TAP);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_MOVE,
        ST_SETTLE,
        ST_FIN
    } state_t;

    state_t             state;
    logic [LANE_W-1:0]  lane_q;
    logic [1:0]         op_q;
    logic               up_q;
    logic               err_q;
    logic [TAP_W-1:0]   remaining;
    logic [CNT_W-1:0]   settle_cnt;
    logic [TAP_W-1:0]   tap [LANES];

    logic               lane_bad_c;
    logic               clamp_c;
    logic               up_c;
    logic               at_limit_c;
    logic               next_limit_c;
    logic [TAP_W-1:0]   cur_tap_c;
    logic [TAP_W-1:0]   target_c;
    logic [TAP_W-1:0]   steps_c;
    logic [TAP_W-1:0]   lane_tap_c;
    logic [TAP_W-1:0]   next_tap_c;

    // Accept-time decode: direction, step count and first-step saturation.
    always_comb begin
        lane_bad_c = {1'b0, CMD_LANE} >= (LANE_W + 1)'(LANES);
        cur_tap_c  = tap[CMD_LANE];
        clamp_c    = (CMD_OP == OP_SET) && (CMD_COUNT > TAP_MAX_V);
        target_c   = clamp_c ? TAP_MAX_V : CMD_COUNT;
        up_c       = 1'b0;
        steps_c    = CMD_COUNT;
        case (CMD_OP)
            OP_INC: up_c = 1'b1;
            OP_SET: begin
                up_c    = target_c > cur_tap_c;
                steps_c = up_c ? (target_c - cur_tap_c) : (cur_tap_c - target_c);
            end
            default: ;
        endcase
        at_limit_c = up_c ? (cur_tap_c >= TAP_MAX_V) : (cur_tap_c == '0);

        lane_tap_c   = tap[lane_q];
        next_tap_c   = up_q ? (lane_tap_c + TAP_W'(1)) : (lane_tap_c - TAP_W'(1));
        next_limit_c = up_q ? (next_tap_c >= TAP_MAX_V) : (next_tap_c == '0);
    end

    // Sequencer: strobes, handshake and tap tracking are all registered here.
    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            state                <= ST_IDLE;
            lane_q               <= '0;
            op_q                 <= OP_LOAD;
            up_q                 <= 1'b0;
            err_q                <= 1'b0;
            remaining            <= '0;
            settle_cnt           <= '0;
            CMD_READY            <= 1'b1;
            DONE                 <= 1'b0;
            DONE_ERR             <= 1'b0;
            BUSY                 <= 1'b0;
            DELAY_LINE_LOAD      <= '0;
            DELAY_LINE_MOVE      <= '0;
            DELAY_LINE_DIRECTION <= '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                tap[i] <= INIT_TAP_V;
            end
        end else begin
            DELAY_LINE_LOAD <= '0;
            DELAY_LINE_MOVE <= '0;
            DONE            <= 1'b0;
            DONE_ERR        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (CMD_VALID) begin
                        lane_q    <= CMD_LANE;
                        op_q      <= CMD_OP;
                        BUSY      <= 1'b1;
                        CMD_READY <= 1'b0;
                        if (lane_bad_c) begin
                            state    <= ST_FIN;
                            DONE     <= 1'b1;
                            DONE_ERR <= 1'b1;
                        end else if (CMD_OP == OP_LOAD) begin
                            DELAY_LINE_LOAD[CMD_LANE] <= 1'b1;
                            state                     <= ST_LOAD;
                        end else if (steps_c == '0) begin
                            state    <= ST_FIN;
                            DONE     <= 1'b1;
                            DONE_ERR <= clamp_c;
                        end else if (at_limit_c) begin
                            state    <= ST_FIN;
                            DONE     <= 1'b1;
                            DONE_ERR <= 1'b1;
                        end else begin
                            DELAY_LINE_DIRECTION[CMD_LANE] <= up_c;
                            up_q      <= up_c;
                            remaining <= steps_c;
                            err_q     <= clamp_c;
                            state     <= ST_SETUP;
                        end
                    end
                end
                ST_LOAD: begin
                    settle_cnt <= CNT_W'(SETTLE_CYC - 1);
                    state      <= ST_SETTLE;
                end
                ST_SETUP: begin
                    DELAY_LINE_MOVE[lane_q] <= 1'b1;
                    state                   <= ST_MOVE;
                end
                ST_MOVE: begin
                    settle_cnt <= CNT_W'(SETTLE_CYC - 1);
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end else if (op_q == OP_LOAD) begin
                        tap[lane_q] <= INIT_TAP_V;
                        state       <= ST_FIN;
                        DONE        <= 1'b1;
                    end else if (DELAY_LINE_OUT_OF_RANGE[lane_q]) begin
                        // IOD refused the step: keep the tracked tap where it was.
                        state    <= ST_FIN;
                        DONE     <= 1'b1;
                        DONE_ERR <= 1'b1;
                    end else begin
                        tap[lane_q] <= next_tap_c;
                        remaining   <= remaining - TAP_W'(1);
                        if (remaining == TAP_W'(1)) begin
                            state    <= ST_FIN;
                            DONE     <= 1'b1;
                            DONE_ERR <= err_q;
                        end else if (next_limit_c) begin
                            state    <= ST_FIN;
                            DONE     <= 1'b1;
                            DONE_ERR <= 1'b1;
                        end else begin
                            state <= ST_SETUP;
                        end
                    end
                end
                ST_FIN: begin
                    BUSY      <= 1'b0;
                    CMD_READY <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_tap
        assign TAP_VALUE[g*TAP_W +: TAP_W] = tap[g];
    end

`ifdef DDR_CA_DLY_STICKY_EN
    logic               settle_end_c;
    logic [LANES-1:0]   sticky;

    assign settle_end_c = (state == ST_SETTLE) && (settle_cnt == '0);

    // Sticky flag: set by any step check that sees out-of-range, cleared by LOAD.
    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            sticky <= '0;
        end else if (settle_end_c) begin
            if (op_q == OP_LOAD) begin
                sticky[lane_q] <= 1'b0;
            end else if (DELAY_LINE_OUT_OF_RANGE[lane_q]) begin
                sticky[lane_q] <= 1'b1;
            end
        end
    end

    assign OOR_STICKY = sticky;
`else
    assign OOR_STICKY = '0;
`endif

endmodule

// File: tb/tb_ddr_ca_dly_ctrl.sv
// Bench for ddr_ca_dly_ctrl: directed vector table, hand-written corner sequences,
// and randomized commands checked against a closed-form model of each command.
module tb_ddr_ca_dly_ctrl;

    localparam int LANES    = 8;
    localparam int TAP_W    = 8;
    localparam int TAP_MAX  = 127;
    localparam int INIT_TAP = 1;
    localparam int S        = 4;
    localparam int STEP     = 2 + S;
    localparam int NVEC     = 12;

`ifdef DDR_CA_DLY_STICKY_EN
    localparam bit STICKY_ON = 1'b1;
`else
    localparam bit STICKY_ON = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [2:0]               cmd_lane;
    logic [1:0]               cmd_op;
    logic [TAP_W-1:0]         cmd_count;
    logic                     done;
    logic                     done_err;
    logic                     busy;
    logic [LANES-1:0]         load;
    logic [LANES-1:0]         move;
    logic [LANES-1:0]         dir;
    logic [LANES-1:0]         oor;
    logic [LANES*TAP_W-1:0]   tap_value;
    logic [LANES-1:0]         sticky;

    int checks = 0;
    int errors = 0;
    int tap_m [LANES];
    logic [LANES-1:0] sticky_m;

    always #5 clk = ~clk;

    ddr_ca_dly_ctrl #(
        .LANES(LANES), .TAP_W(TAP_W), .TAP_MAX(TAP_MAX),
        .INIT_TAP(INIT_TAP), .SETTLE_CYC(S)
    ) dut (
        .FAB_CLK                 (clk),
        .SYNC_RST                (rst),
        .CMD_VALID               (cmd_valid),
        .CMD_READY               (cmd_ready),
        .CMD_LANE                (cmd_lane),
        .CMD_OP                  (cmd_op),
        .CMD_COUNT               (cmd_count),
        .DONE                    (done),
        .DONE_ERR                (done_err),
        .BUSY                    (busy),
        .DELAY_LINE_LOAD         (load),
        .DELAY_LINE_MOVE         (move),
        .DELAY_LINE_DIRECTION    (dir),
        .DELAY_LINE_OUT_OF_RANGE (oor),
        .TAP_VALUE               (tap_value),
        .OOR_STICKY              (sticky)
    );

    typedef struct {
        int lane;
        int op;
        int count;
        int oor_at;
        bit hold;
        int exp_tap;
        int exp_err;
        int exp_done;
        int exp_moves;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic logic [LANES*TAP_W-1:0] pack_taps();
        logic [LANES*TAP_W-1:0] b;
        b = '0;
        for (int i = 0; i < LANES; i++) b[i*TAP_W +: TAP_W] = TAP_W'(tap_m[i]);
        return b;
    endfunction

    // Closed-form outcome of one command from the controller's rules.
    function automatic void model(input int tap, input int op, input int count, input int oor_at,
                                  output int ntap, output int err, output int moves,
                                  output int done_cyc, output bit hit);
        int up, steps, lim, taken, t;
        err = 0;
        hit = 1'b0;
        if (op == 0) begin
            ntap = INIT_TAP; moves = 0; done_cyc = 2 + S;
            return;
        end
        if (op == 1) begin up = 1; steps = count; end
        else if (op == 2) begin up = 0; steps = count; end
        else begin
            t = (count > TAP_MAX) ? TAP_MAX : count;
            err = (count > TAP_MAX) ? 1 : 0;
            up = (t > tap) ? 1 : 0;
            steps = up ? t - tap : tap - t;
        end
        lim = up ? TAP_MAX - tap : tap;
        taken = steps;
        if (steps > lim) begin taken = lim; err = 1; end
        if (oor_at > 0 && oor_at <= taken) begin
            hit = 1'b1; err = 1; moves = oor_at;
            ntap = up ? tap + oor_at - 1 : tap - oor_at + 1;
        end else begin
            moves = taken;
            ntap = up ? tap + taken : tap - taken;
        end
        done_cyc = (moves == 0) ? 1 : 1 + moves * STEP;
    endfunction

    // Issue one command at a negedge; returns after the cycle following DONE.
    task automatic run_cmd(input int lane, input int op, input int count, input int oor_at,
                           input bit hold, output int done_cyc, output int err_o, output int moves);
        int cyc;
        bit got, tim_bad, busy_bad, stray, dir_bad, load_bad, exp_up;
        int loads;
        logic [LANES-1:0] sel;
        cyc = 0; got = 0; tim_bad = 0; busy_bad = 0; stray = 0; dir_bad = 0; load_bad = 0;
        loads = 0; moves = 0; done_cyc = -1; err_o = -1;
        sel = '0;
        sel[lane] = 1'b1;
        exp_up = (op == 1) || (op == 3 && count > tap_m[lane]);
        check("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_lane  = 3'(lane);
        cmd_op    = 2'(op);
        cmd_count = TAP_W'(count);
        while (!got && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                if (hold) begin
                    cmd_lane = 3'((lane + 1) % LANES); cmd_op = 2'd1; cmd_count = 8'd3;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (((move & ~sel) != '0) || ((load & ~sel) != '0)) stray = 1;
            if (load[lane]) begin
                loads++;
                if (op != 0 || cyc != 1) load_bad = 1;
            end
            if (move[lane]) begin
                if (cyc != 2 + moves * STEP) tim_bad = 1;
                if (dir[lane] !== exp_up) dir_bad = 1;
                moves++;
                if (moves == oor_at) oor[lane] = 1'b1;
            end
            if (!busy || cmd_ready) busy_bad = 1;
            if (done) begin
                got = 1; done_cyc = cyc; err_o = int'(done_err); cmd_valid = 1'b0;
            end
        end
        check("done_seen", got, 1);
        oor = '0;
        cmd_valid = 1'b0;
        check("load_strobe_count", loads, (op == 0) ? 1 : 0);
        check("load_strobe_cycle", load_bad, 0);
        check("stray_strobe", stray, 0);
        check("move_spacing", tim_bad, 0);
        check("move_direction", dir_bad, 0);
        check("busy_window", busy_bad, 0);
        @(negedge clk);
        check("ready_after_done", cmd_ready, 1);
        check("busy_after_done", busy, 0);
        check("single_done", done, 0);
    endtask

    initial begin
        int dc, er, mv, ntap, eerr, emov, edone, c, m2;
        int lane, op, cnt, oa;
        bit hit;

        vecs[0]  = '{3, 0, 0,   0, 1'b0, 1,   0, 6,   0};
        vecs[1]  = '{0, 1, 5,   0, 1'b1, 6,   0, 31,  5};
        vecs[2]  = '{2, 3, 0,   0, 1'b0, 0,   0, 7,   1};
        vecs[3]  = '{2, 2, 1,   0, 1'b0, 0,   1, 1,   0};
        vecs[4]  = '{1, 1, 10,  3, 1'b0, 3,   1, 19,  3};
        vecs[5]  = '{4, 3, 200, 0, 1'b0, 127, 1, 757, 126};
        vecs[6]  = '{4, 1, 1,   0, 1'b0, 127, 1, 1,   0};
        vecs[7]  = '{5, 1, 0,   0, 1'b0, 1,   0, 1,   0};
        vecs[8]  = '{5, 3, 1,   0, 1'b0, 1,   0, 1,   0};
        vecs[9]  = '{0, 2, 7,   0, 1'b0, 0,   1, 37,  6};
        vecs[10] = '{4, 0, 0,   0, 1'b0, 1,   0, 6,   0};
        vecs[11] = '{6, 3, 3,   0, 1'b0, 3,   0, 13,  2};

        rst = 1'b1; cmd_valid = 1'b0; cmd_lane = '0; cmd_op = '0; cmd_count = '0; oor = '0;
        for (int i = 0; i < LANES; i++) tap_m[i] = INIT_TAP;
        sticky_m = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", cmd_ready, 1);
        check("rst_done", done, 0);
        check("rst_done_err", done_err, 0);
        check("rst_busy", busy, 0);
        check("rst_load", load, 0);
        check("rst_move", move, 0);
        check("rst_dir", dir, 0);
        check("rst_taps", tap_value, pack_taps());
        check("rst_sticky", sticky, 0);
        rst = 1'b0;
        @(negedge clk);
        check("no_load_after_rst", load, 0);

        for (int v = 0; v < NVEC; v++) begin
            run_cmd(vecs[v].lane, vecs[v].op, vecs[v].count, vecs[v].oor_at, vecs[v].hold, dc, er, mv);
            check("vec_done_cycle", dc, vecs[v].exp_done);
            check("vec_done_err", er, vecs[v].exp_err);
            check("vec_moves", mv, vecs[v].exp_moves);
            tap_m[vecs[v].lane] = vecs[v].exp_tap;
            check("vec_taps", tap_value, pack_taps());
        end

        check("sticky_after_oor", sticky, STICKY_ON ? 8'h02 : 8'h00);
        run_cmd(1, 0, 0, 0, 1'b0, dc, er, mv);
        check("load1_done_cycle", dc, 2 + S);
        tap_m[1] = INIT_TAP;
        check("load1_taps", tap_value, pack_taps());
        check("sticky_after_load", sticky, 0);

        // Reset during the second MOVE of an INC.
        cmd_valid = 1'b1; cmd_lane = 3'd2; cmd_op = 2'd1; cmd_count = 8'd5;
        c = 0; m2 = 0;
        while (m2 < 2 && c < 100) begin
            @(negedge clk);
            c++;
            if (c == 1) cmd_valid = 1'b0;
            if (move[2]) m2++;
        end
        check("mid_rst_second_move_cycle", c, 2 + STEP);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < LANES; i++) tap_m[i] = INIT_TAP;
        sticky_m = '0;
        check("mid_rst_move", move, 0);
        check("mid_rst_load", load, 0);
        check("mid_rst_dir", dir, 0);
        check("mid_rst_taps", tap_value, pack_taps());
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_busy", busy, 0);
        rst = 1'b0;
        c = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) c++;
        end
        check("mid_rst_no_done", c, 0);

        for (int k = 0; k < 40; k++) begin
            lane = $urandom_range(0, LANES - 1);
            op   = $urandom_range(0, 3);
            cnt  = (op == 3) ? $urandom_range(0, 140) : $urandom_range(0, 10);
            oa   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
            model(tap_m[lane], op, cnt, oa, ntap, eerr, emov, edone, hit);
            run_cmd(lane, op, cnt, oa, 1'b0, dc, er, mv);
            check("rnd_done_cycle", dc, edone);
            check("rnd_done_err", er, eerr);
            check("rnd_moves", mv, emov);
            tap_m[lane] = ntap;
            if (op == 0) sticky_m[lane] = 1'b0;
            else if (hit) sticky_m[lane] = 1'b1;
            check("rnd_taps", tap_value, pack_taps());
            check("rnd_sticky", sticky, STICKY_ON ? sticky_m : '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr_ca_dly_ctrl.md
# ddr_ca_dly_ctrl

Parametrised delay-line controller for the DDR3 command/address IOD lanes (CAS_N, RAS_N, WE_N, address, bank). It drives per-lane DELAY_LINE_MOVE/DIRECTION/LOAD strobes into the PolarFire IOD primitives from a single command port. It tracks the tap position of every lane and reports saturation and out-of-range. It sits in the DDRPHY block between the training sequencer and the CA lane IOD wrappers, and replaces the fixed single-lane hookup.

## Interface
- LANES, 8, number of CA lanes controlled (>=2)
- TAP_W, 8, width of the tap counter and of CMD_COUNT
- TAP_MAX, 127, highest legal tap value
- INIT_TAP, 1, tap value after a LOAD (matches IOD TX_DELAY_VAL)
- SETTLE_CYC, 4, wait cycles after each strobe before the next step or OOR check (>=1)

Ports:
- FAB_CLK  in  1  fabric clock; all logic on rising edge
- SYNC_RST  in  1  reset, synchronous, active-high
- CMD_VALID  in  1  command request
- CMD_READY  out  1  command accepted when VALID&READY
- CMD_LANE  in  $clog2(LANES)  target lane
- CMD_OP  in  2  00 LOAD, 01 INC, 10 DEC, 11 SET absolute
- CMD_COUNT  in  TAP_W  step count (INC/DEC) or target tap (SET)
- DONE  out  1  one-cycle pulse at command completion
- DONE_ERR  out  1  valid with DONE; 1 = saturated or out-of-range
- BUSY  out  1  high from accept until DONE inclusive
- DELAY_LINE_LOAD  out  LANES  per-lane load strobe
- DELAY_LINE_MOVE  out  LANES  per-lane move strobe
- DELAY_LINE_DIRECTION  out  LANES  per-lane direction, 1 = increase delay
- DELAY_LINE_OUT_OF_RANGE  in  LANES  per-lane IOD out-of-range flag
- TAP_VALUE  out  LANES*TAP_W  tracked tap per lane, lane i at [i*TAP_W +: TAP_W]
- OOR_STICKY  out  LANES  sticky out-of-range status (see Configuration)

## Operation
- FSM states: IDLE, LOAD, SETUP, MOVE, SETTLE, FIN.
- IDLE: CMD_READY=1. On accept, latch lane, op, and count. Out-of-range CMD_LANE (>=LANES) completes immediately with DONE_ERR=1 and no strobes.
- LOAD: DELAY_LINE_LOAD[lane]=1 for one cycle. Then SETTLE, then FIN; TAP_VALUE[lane]=INIT_TAP.
- INC/DEC: remaining steps = CMD_COUNT.
- SET: delta = |CMD_COUNT - TAP_VALUE[lane]|; direction from the sign. CMD_COUNT>TAP_MAX is clamped to TAP_MAX and flags an error.
- Zero steps go directly to FIN with no strobe.
- SETUP: drive DIRECTION[lane] for one cycle before MOVE. Hold it stable through MOVE and SETTLE.
- Before each step: if the step would go past TAP_MAX (inc) or below 0 (dec), do not strobe; go to FIN with the error set.
- MOVE: DELAY_LINE_MOVE[lane]=1 for exactly one cycle.
- SETTLE: wait SETTLE_CYC cycles, then sample OUT_OF_RANGE[lane].
  - If 1: the tap is not updated, error set, go to FIN.
  - Else: tap ±1, decrement remaining, go to SETUP if remaining>0, else FIN.
- FIN: DONE=1 for one cycle, return to IDLE.
- Unselected lanes' strobes are always 0. DIRECTION of idle lanes holds its last value.
- CMD inputs are ignored while BUSY. Commands are never queued.

## Timing
- Reset values:
  - CMD_READY=1; DONE, DONE_ERR, BUSY = 0.
  - All LOAD/MOVE/DIRECTION = 0.
  - Every TAP_VALUE lane = INIT_TAP; OOR_STICKY=0; FSM=IDLE.
- Reset does not pulse LOAD; the IOD resets to its own TX_DELAY_VAL.
- Latencies from the accept cycle (cycle 0):
  - LOAD: strobe in cycle 1, DONE in cycle 2+SETTLE_CYC.
  - INC/DEC of N steps: first MOVE in cycle 2. Each step takes 2+SETTLE_CYC cycles. DONE in cycle 1+N*(2+SETTLE_CYC).
  - Zero-step command: DONE in cycle 1.
- SYNC_RST mid-command: all strobes deassert on the next edge, all state returns to reset values, and no DONE is issued.
- TAP_VALUE updates on the edge that leaves SETTLE.

## Configuration
- DDR_CA_DLY_STICKY_EN defined:
  - OOR_STICKY[i] sets whenever a SETTLE check on lane i sees OUT_OF_RANGE.
  - It clears on a LOAD of lane i or on reset.
- Not defined: OOR_STICKY is tied 0 and the logic is removed. The port stays present.

## Test plan
- Reset, then LOAD lane 3 with SETTLE_CYC=4 → LOAD[3] pulse in cycle 1, DONE in cycle 6, DONE_ERR=0, TAP_VALUE lane3=1.
- INC lane 0 by 5 → 5 MOVE pulses 6 cycles apart, DIRECTION[0]=1, final tap 6, DONE in cycle 31.
- SET lane 2 to 0 from tap 1 → one MOVE with DIRECTION=0, tap 0. Then DEC by 1 → no strobe, DONE_ERR=1, tap stays 0.
- INC lane 1 by 10 with OUT_OF_RANGE[1] forced high after the 3rd move → stop at tap 3 (INIT 1 +2), DONE_ERR=1, OOR_STICKY[1]=1 (macro on) or 0 (off).
- Assert SYNC_RST during the 2nd MOVE of an INC → strobes 0 next cycle, all taps back to 1, no DONE, CMD_READY=1.
- CMD_VALID held during BUSY with a different lane → ignored; exactly one DONE per accepted command.
